// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo counter.
//   counter_mode_t : boundary behaviour selector (WRAP, SATURATE, ONESHOT, MODE_RSVD)
//   is_wrap()      : true for modes that wrap at the range boundary
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP      = 2'd0,
        SATURATE  = 2'd1,
        ONESHOT   = 2'd2,
        MODE_RSVD = 2'd3
    } counter_mode_t;

    // The reserved encoding behaves exactly like WRAP.
    function automatic logic is_wrap(counter_mode_t mode);
        return (mode == WRAP) || (mode == MODE_RSVD);
    endfunction

endpackage

// File: rtl/modulo_next_value.sv
// Combinational next-value arithmetic for the modulo counter.
// Ports:
//   value      in  current count
//   step       in  advance amount (zero-extended)
//   limit      in  inclusive upper bound of the range 0..limit
//   decrement  in  1 = count down, 0 = count up
//   mode       in  counter_mode_t encoding
//   next_value out value after one advance
//   wrap       out the advance crossed the boundary in a wrapping mode
//   clamp      out the advance was clamped in SATURATE/ONESHOT
//   illegal    out step exceeds the range size in a wrapping mode
module modulo_next_value
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STEP_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      value,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  decrement,
    input  logic [1:0]            mode,
    output logic [WIDTH-1:0]      next_value,
    output logic                  wrap,
    output logic                  clamp,
    output logic                  illegal
);

    counter_mode_t mode_e;
    logic [WIDTH:0] s_ext;
    logic [WIDTH:0] v_ext;
    logic [WIDTH:0] lim_ext;
    logic [WIDTH:0] lim1;
    logic [WIDTH:0] sum;

    assign mode_e  = counter_mode_t'(mode);
    assign s_ext   = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign v_ext   = {1'b0, value};
    assign lim_ext = {1'b0, limit};
    assign lim1    = lim_ext + {{WIDTH{1'b0}}, 1'b1};
    assign sum     = v_ext + s_ext;

    // Comparisons use WIDTH+1 bits; the wrapped results are exact modulo 2^WIDTH,
    // so they are formed directly in WIDTH bits.
    always_comb begin
        next_value = value;
        wrap       = 1'b0;
        clamp      = 1'b0;
        illegal    = 1'b0;
        if (s_ext == '0) begin
            next_value = value;
        end else if (is_wrap(mode_e) && (s_ext > lim1)) begin
            illegal    = 1'b1;
            next_value = '0;
        end else if (!decrement) begin
            if (sum <= lim_ext) begin
                next_value = sum[WIDTH-1:0];
            end else if (is_wrap(mode_e)) begin
                next_value = sum[WIDTH-1:0] - lim1[WIDTH-1:0];
                wrap       = 1'b1;
            end else begin
                next_value = limit;
                clamp      = 1'b1;
            end
        end else begin
            if (v_ext >= s_ext) begin
                next_value = value - s_ext[WIDTH-1:0];
            end else if (is_wrap(mode_e)) begin
                next_value = value + lim1[WIDTH-1:0] - s_ext[WIDTH-1:0];
                wrap       = 1'b1;
            end else begin
                next_value = '0;
                clamp      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modulo_counter.sv
// Modulo up/down counter with enable, programmable step and limit, and
// wrap / saturate / one-shot boundary modes.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   enable        advance this cycle
//   decrement     1 = count down
//   setvalue      load valuein (clamped to limit, overflow if clamped)
//   valuein       load value
//   step          advance amount
//   limit         inclusive range bound, sampled every cycle
//   mode          counter_mode_t encoding
//   clear_flags   clears overflow and done
//   valueout      registered count
//   terminal      combinational boundary indicator for the current direction
//   wrapped       one-cycle pulse after a wrap
//   saturated     last advance was clamped
//   done          sticky: one-shot reached its bound
//   overflow      sticky: illegal load or step
module modulo_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     STEP_WIDTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  decrement,
    input  logic                  setvalue,
    input  logic [WIDTH-1:0]      valuein,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    input  logic [1:0]            mode,
    input  logic                  clear_flags,
    output logic [WIDTH-1:0]      valueout,
    output logic                  terminal,
    output logic                  wrapped,
    output logic                  saturated,
    output logic                  done,
    output logic                  overflow
);

    counter_mode_t mode_e;

    logic [WIDTH-1:0] value_q, value_d;
    logic             wrapped_q, wrapped_d;
    logic             saturated_q, saturated_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] nv_value;
    logic             nv_wrap;
    logic             nv_clamp;
    logic             nv_illegal;
    logic             advance;

    assign mode_e = counter_mode_t'(mode);

    modulo_next_value #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_next (
        .value      (value_q),
        .step       (step),
        .limit      (limit),
        .decrement  (decrement),
        .mode       (mode),
        .next_value (nv_value),
        .wrap       (nv_wrap),
        .clamp      (nv_clamp),
        .illegal    (nv_illegal)
    );

    // A finished one-shot ignores enables until done is cleared or a load occurs.
    assign advance = enable && !((mode_e == ONESHOT) && done_q);

    always_comb begin
        value_d     = value_q;
        wrapped_d   = 1'b0;
        saturated_d = saturated_q;
        done_d      = done_q;
        overflow_d  = overflow_q;

        // Clear first so a same-cycle overflow event below wins.
        if (clear_flags) begin
            overflow_d = 1'b0;
            done_d     = 1'b0;
        end

        if (setvalue) begin
            saturated_d = 1'b0;
            done_d      = 1'b0;
            if (valuein > limit) begin
                value_d    = limit;
                overflow_d = 1'b1;
            end else begin
                value_d = valuein;
            end
        end else if (advance && (step != '0)) begin
            value_d     = nv_value;
            wrapped_d   = nv_wrap;
            saturated_d = nv_clamp;
            if (nv_illegal) begin
                overflow_d = 1'b1;
            end
            if (nv_clamp && (mode_e == ONESHOT)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q     <= RESET_VALUE;
            wrapped_q   <= 1'b0;
            saturated_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            value_q     <= value_d;
            wrapped_q   <= wrapped_d;
            saturated_q <= saturated_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign valueout  = value_q;
    assign wrapped   = wrapped_q;
    assign saturated = saturated_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign terminal  = decrement ? (value_q == '0) : (value_q == limit);

endmodule

// File: tb/tb_modulo_counter.sv
module tb_modulo_counter;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned STEP_WIDTH = 4;

    typedef struct {
        logic [12:0] vec;   // {valueout, terminal, wrapped, saturated, done, overflow}
        string       tag;
    } exp_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  enable = 1'b0;
    logic                  decrement = 1'b0;
    logic                  setvalue = 1'b0;
    logic [WIDTH-1:0]      valuein = '0;
    logic [STEP_WIDTH-1:0] step = '0;
    logic [WIDTH-1:0]      limit = '0;
    logic [1:0]            mode = 2'd0;
    logic                  clear_flags = 1'b0;
    logic [WIDTH-1:0]      valueout;
    logic                  terminal;
    logic                  wrapped;
    logic                  saturated;
    logic                  done;
    logic                  overflow;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    modulo_counter #(
        .WIDTH       (WIDTH),
        .STEP_WIDTH  (STEP_WIDTH),
        .RESET_VALUE (8'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .decrement   (decrement),
        .setvalue    (setvalue),
        .valuein     (valuein),
        .step        (step),
        .limit       (limit),
        .mode        (mode),
        .clear_flags (clear_flags),
        .valueout    (valueout),
        .terminal    (terminal),
        .wrapped     (wrapped),
        .saturated   (saturated),
        .done        (done),
        .overflow    (overflow)
    );

    // Push expectation for the current inputs, clock once, then pop and compare.
    task automatic cyc(input logic [7:0] v, input logic t, input logic w, input logic s,
                       input logic d, input logic o, input string tag);
        exp_t e;
        exp_t got;
        logic [12:0] obs;
        e.vec = {v, t, w, s, d, o};
        e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        obs = {valueout, terminal, wrapped, saturated, done, overflow};
        checks++;
        assert (obs === got.vec) else begin
            failures++;
            $error("FAIL %s observed={v=%0d t%b w%b s%b d%b o%b} expected={v=%0d t%b w%b s%b d%b o%b}",
                   got.tag, obs[12:5], obs[4], obs[3], obs[2], obs[1], obs[0],
                   got.vec[12:5], got.vec[4], got.vec[3], got.vec[2], got.vec[1], got.vec[0]);
        end
    endtask

    initial begin
        // 1: reset, then wrap-up over 0..9
        @(posedge clock);
        #1;
        reset = 1'b1; limit = 8'd9; step = 4'd1; mode = 2'd0;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        reset = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(8'(i % 10), (i == 9), (i == 10), 1'b0, 1'b0, 1'b0, "wrap_up");
        end

        // 2: down wrap with step 3
        enable = 1'b0; setvalue = 1'b1; valuein = 8'd1; decrement = 1'b1; step = 4'd3;
        cyc(8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "load_1");
        setvalue = 1'b0; enable = 1'b1;
        cyc(8'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "down_wrap_8");
        cyc(8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "down_5");
        cyc(8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "down_2");
        cyc(8'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "down_wrap_9");

        // 3: saturate, then one-shot
        enable = 1'b0; decrement = 1'b0; mode = 2'd1; limit = 8'd200; step = 4'd5;
        setvalue = 1'b1; valuein = 8'd198;
        cyc(8'd198, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "load_198");
        setvalue = 1'b0; enable = 1'b1;
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sat_clamp");
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sat_stay");
        enable = 1'b0;
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sat_hold_idle");
        mode = 2'd2; setvalue = 1'b1;
        cyc(8'd198, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "oneshot_load");
        setvalue = 1'b0; enable = 1'b1;
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "oneshot_done");
        valuein = 8'd0;
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "oneshot_ignored");
        enable = 1'b0; clear_flags = 1'b1;
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "clear_done");
        clear_flags = 1'b0; enable = 1'b1;
        cyc(8'd200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "oneshot_redone");

        // 4: load priority over enable, reset priority over load
        mode = 2'd0; limit = 8'd40; setvalue = 1'b1; valuein = 8'd50;
        cyc(8'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "load_clamp_ovf");
        reset = 1'b1;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_over_load");
        reset = 1'b0; enable = 1'b0; clear_flags = 1'b1;
        cyc(8'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_beats_clear");
        setvalue = 1'b0;
        cyc(8'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "clear_ovf");
        clear_flags = 1'b0;

        // 5: illegal step while value sits above a lowered limit
        limit = 8'd3; step = 4'd6; enable = 1'b1;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "illegal_step");
        enable = 1'b0; clear_flags = 1'b1;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "illegal_clear");
        clear_flags = 1'b0; step = 4'd0; enable = 1'b1;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "step_zero");

        // 6: full range
        limit = 8'd255; step = 4'd1; enable = 1'b0; setvalue = 1'b1; valuein = 8'd255;
        cyc(8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "load_255");
        setvalue = 1'b0; enable = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "full_wrap_up");
        decrement = 1'b1;
        cyc(8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "full_wrap_down");
        enable = 1'b0;
        cyc(8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wrap_pulse_ends");

        // One-shot down clamp to zero
        mode = 2'd2; step = 4'd5; setvalue = 1'b1; valuein = 8'd2;
        cyc(8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "load_2");
        setvalue = 1'b0; enable = 1'b1;
        cyc(8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "oneshot_down_clamp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
